stream_demux: RTL

//  1:2 registered stream demultiplexer; the splitting counterpart of the 2:1 mux.

---
 rtl/stream_demux_if.sv | 38 +++
 rtl/stream_demux.sv | 99 +++++++++
 2 files changed

// File: rtl/stream_demux_if.sv
// Handshake bundle for the 1:2 stream demultiplexer: one input stream, two output streams.
// The optional cnt0/cnt1 ports exist only when DEMUX_CNT_EN is defined.
interface stream_demux_if #(
  parameter int width_size = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [width_size:0] in_data;
  logic              out0_valid;
  logic              out0_ready;
  logic [width_size:0] out0_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [width_size:0] out1_data;
`ifdef DEMUX_CNT_EN
  logic [7:0]        cnt0;
  logic [7:0]        cnt1;
`endif

  // Environment side: produces the input stream and consumes both output streams.
  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_CNT_EN
    , input cnt0, cnt1
`endif
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_CNT_EN
    , output cnt0, cnt1
`endif
  );
endinterface

// File: rtl/stream_demux.sv
// 1:2 registered stream demultiplexer with an independent one-entry holding register per port.
// Optional feature: define DEMUX_CNT_EN to add the per-port delivered-word counters cnt0/cnt1.
module stream_demux #(
  parameter int width_size = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;

  port_state_e         state_q [2];
  port_state_e         state_d [2];
  logic [width_size:0] data_q  [2];
  logic [width_size:0] data_d  [2];

  logic [1:0] out_ready;
  logic [1:0] can_load;
  logic [1:0] load;
  logic [1:0] deliver;
  logic       accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // A full port frees its slot in the same cycle its sink takes the word, so no bubble.
  assign can_load[0] = (state_q[0] == EMPTY) | out_ready[0];
  assign can_load[1] = (state_q[1] == EMPTY) | out_ready[1];

  // Gated by rst_n so nothing is offered as accepted while the block is held in reset.
  assign bus.in_ready = rst_n & can_load[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      load[k]    = accept & (bus.in_sel == 1'(k));
      deliver[k] = (state_q[k] == FULL) & out_ready[k];
      if (load[k]) begin
        state_d[k] = FULL;
        data_d[k]  = bus.in_data;
      end else if (deliver[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= EMPTY;
        // NOTE: the data registers are reset too, because the outputs must read zero after reset.
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out1_valid = (state_q[1] == FULL);
  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];

  // Counts completed transfers; an 8-bit add wraps FF -> 00 by itself.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k] + 8'(deliver[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
`endif
endmodule
